// File: rtl/forth_cmp_pkg.sv
// rtl/forth_cmp_pkg.sv - op codes, FSM states, flag encodings and op decode helpers
package forth_cmp_pkg;

  typedef enum logic [3:0] {
    OP_EQ  = 4'd0,
    OP_NE  = 4'd1,
    OP_LT  = 4'd2,
    OP_LE  = 4'd3,
    OP_GT  = 4'd4,
    OP_GE  = 4'd5,
    OP_ULT = 4'd6,
    OP_UGT = 4'd7,
    OP_ZEQ = 4'd8,
    OP_ZLT = 4'd9,
    OP_ZGT = 4'd10
  } op_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // {eq,neq,lt,lte,gt,gte}
  localparam logic [5:0] LT = 6'b011100;
  localparam logic [5:0] EQ = 6'b100101;
  localparam logic [5:0] GT = 6'b010011;

  function automatic logic op_legal(input logic [3:0] op);
    return op <= 4'd10;
  endfunction

  // Illegal codes scan unsigned; only their flags are reported
  function automatic logic op_signed(input logic [3:0] op);
    return op_legal(op) && (op != OP_ULT) && (op != OP_UGT);
  endfunction

  function automatic logic op_zero(input logic [3:0] op);
    return (op == OP_ZEQ) || (op == OP_ZLT) || (op == OP_ZGT);
  endfunction

  function automatic logic rel_holds(input logic [3:0] op, input logic [5:0] flg);
    logic r;
    case (op)
      OP_EQ, OP_ZEQ:         r = flg[5];
      OP_NE:                 r = flg[4];
      OP_LT, OP_ULT, OP_ZLT: r = flg[3];
      OP_LE:                 r = flg[2];
      OP_GT, OP_UGT, OP_ZGT: r = flg[1];
      OP_GE:                 r = flg[0];
      default:               r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/forth_cmp_if.sv
// rtl/forth_cmp_if.sv - request/result handshake bundle of the Forth comparator
interface forth_cmp_if #(parameter int N = 32) ();
  logic         i_vld;
  logic         i_rdy;
  logic [3:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         o_vld;
  logic         o_rdy;
  logic [5:0]   o_flg;
  logic [N-1:0] o_tos;
  logic         o_err;

  modport master (output i_vld, op, a, b, o_rdy,
                  input  i_rdy, o_vld, o_flg, o_tos, o_err);
  modport slave  (input  i_vld, op, a, b, o_rdy,
                  output i_rdy, o_vld, o_flg, o_tos, o_err);
endinterface

// File: rtl/forth_cmp_digit.sv
// rtl/forth_cmp_digit.sv - combinational unsigned compare of one D-bit digit
module cmp_digit #(parameter int D = 4) (
  input  logic [D-1:0] i_a,
  input  logic [D-1:0] i_b,
  output logic         o_lt,
  output logic         o_eq,
  output logic         o_gt
);
  assign o_lt = (i_a < i_b);
  assign o_eq = (i_a == i_b);
  assign o_gt = (i_a > i_b);
endmodule

// File: rtl/forth_cmp.sv
// rtl/forth_cmp.sv - digit-serial Forth comparison word unit, MSB digit first
module forth_cmp
  import forth_cmp_pkg::*;
#(
  parameter int N = 32,
  parameter int D = 4
) (
  input  logic        clk,
  input  logic        rst,
  forth_cmp_if.slave  bus
);
  localparam int ND = N / D;
  localparam int JW = (ND > 1) ? $clog2(ND) : 1;

  logic [1:0]    r_state;
  logic [JW-1:0] r_j;
  logic [3:0]    r_op;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic          r_vld;
  logic [5:0]    r_flg;
  logic [N-1:0]  r_tos;
  logic          r_err;

  logic [N-1:0]  w_msb;
  logic [N-1:0]  w_a_in;
  logic [N-1:0]  w_b_in;
  logic          w_lt;
  logic          w_eq;
  logic          w_gt;
  logic          w_last;
  logic [5:0]    w_flg;

  // Flipping the sign bit maps two's complement order onto unsigned order
  assign w_msb  = {op_signed(bus.op), {(N-1){1'b0}}};
  assign w_a_in = bus.a ^ w_msb;
  assign w_b_in = (op_zero(bus.op) ? '0 : bus.b) ^ w_msb;

  // Operands shift left each scan cycle, so digit j is always the top digit
  cmp_digit #(.D(D)) u_digit (
    .i_a  (r_a[N-1 -: D]),
    .i_b  (r_b[N-1 -: D]),
    .o_lt (w_lt),
    .o_eq (w_eq),
    .o_gt (w_gt)
  );

  assign w_last = (r_j == JW'(ND - 1));
  assign w_flg  = w_lt ? LT : (w_gt ? GT : EQ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_j     <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_vld   <= 1'b0;
      r_flg   <= '0;
      r_tos   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.i_vld) begin
            r_op    <= bus.op;
            r_a     <= w_a_in;
            r_b     <= w_b_in;
            r_j     <= '0;
            r_state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (!w_eq || w_last) begin
            r_state <= ST_DONE;
            r_vld   <= 1'b1;
            r_flg   <= w_flg;
            r_tos   <= {N{rel_holds(r_op, w_flg)}};
            r_err   <= !op_legal(r_op);
          end else begin
            r_j <= r_j + JW'(1);
            r_a <= r_a << D;
            r_b <= r_b << D;
          end
        end
        ST_DONE: begin
          if (bus.o_rdy) begin
            r_state <= ST_IDLE;
            r_vld   <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.i_rdy = (r_state == ST_IDLE);
  assign bus.o_vld = r_vld;
  assign bus.o_flg = r_flg;
  assign bus.o_tos = r_tos;
  assign bus.o_err = r_err;

endmodule

// File: tb/tb_forth_cmp.sv
// tb/tb_forth_cmp.sv - directed-vector self-checking bench for forth_cmp
module tb_forth_cmp;
  import forth_cmp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  forth_cmp_if #(.N(32)) bus ();

  forth_cmp #(.N(32), .D(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req(input string tag, input logic [3:0] op_i, input logic [31:0] a_i,
                     input logic [31:0] b_i, input logic [5:0] ef, input logic [31:0] et,
                     input logic ee, input int elat);
    int lat;
    @(negedge clk);
    chk({tag, " i_rdy"}, 64'(bus.i_rdy), 64'd1);
    bus.i_vld = 1'b1;
    bus.op    = op_i;
    bus.a     = a_i;
    bus.b     = b_i;
    @(posedge clk);
    #1;
    bus.i_vld = 1'b0;
    bus.op    = 4'(~op_i);
    bus.a     = $urandom;
    bus.b     = $urandom;
    lat = 0;
    while (!bus.o_vld && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, " lat"}, 64'(lat), 64'(elat));
    chk({tag, " flg"}, 64'(bus.o_flg), 64'(ef));
    chk({tag, " tos"}, 64'(bus.o_tos), 64'(et));
    chk({tag, " err"}, 64'(bus.o_err), 64'(ee));
    @(negedge clk);
    bus.o_rdy = 1'b1;
    @(posedge clk);
    #1;
    bus.o_rdy = 1'b0;
    chk({tag, " vld_drop"}, 64'(bus.o_vld), 64'd0);
    chk({tag, " rdy_back"}, 64'(bus.i_rdy), 64'd1);
  endtask

  initial begin
    bus.i_vld = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    bus.o_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst i_rdy", 64'(bus.i_rdy), 64'd1);
    chk("rst o_vld", 64'(bus.o_vld), 64'd0);
    chk("rst o_flg", 64'(bus.o_flg), 64'd0);
    chk("rst o_tos", 64'(bus.o_tos), 64'd0);
    chk("rst o_err", 64'(bus.o_err), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    req("lt_0_1",    OP_LT,  32'h0,        32'h1,        LT, 32'hFFFFFFFF, 1'b0, 8);
    req("ult_m1_0",  OP_ULT, 32'hFFFFFFFF, 32'h0,        GT, 32'h0,        1'b0, 1);
    req("lt_m1_0",   OP_LT,  32'hFFFFFFFF, 32'h0,        LT, 32'hFFFFFFFF, 1'b0, 1);
    req("eq_max",    OP_EQ,  32'h7FFFFFFF, 32'h7FFFFFFF, EQ, 32'hFFFFFFFF, 1'b0, 8);
    req("ge_less",   OP_GE,  32'h7FFFFFFE, 32'h7FFFFFFF, LT, 32'h0,        1'b0, 8);
    req("illegal",   4'd15,  32'h1,        32'h0,        GT, 32'h0,        1'b1, 8);
    req("zlt_min",   OP_ZLT, 32'h80000000, 32'h5,        LT, 32'hFFFFFFFF, 1'b0, 1);
    req("ne_same",   OP_NE,  32'h5,        32'h5,        EQ, 32'h0,        1'b0, 8);
    req("ugt_j6",    OP_UGT, 32'h12345678, 32'h12345600, GT, 32'hFFFFFFFF, 1'b0, 7);
    req("le_same",   OP_LE,  32'h3,        32'h3,        EQ, 32'hFFFFFFFF, 1'b0, 8);
    req("zeq_zero",  OP_ZEQ, 32'h0,        32'h9,        EQ, 32'hFFFFFFFF, 1'b0, 8);
    req("zgt_j5",    OP_ZGT, 32'h00000100, 32'hFFFFFFFF, GT, 32'hFFFFFFFF, 1'b0, 6);
    req("gt_neg",    OP_GT,  32'hFFFFFFFF, 32'hFFFFFFFE, GT, 32'hFFFFFFFF, 1'b0, 8);

    // Result stall with a request held pending the whole time
    @(negedge clk);
    bus.i_vld = 1'b1;
    bus.op    = OP_ULT;
    bus.a     = 32'h10000000;
    bus.b     = 32'h20000000;
    @(posedge clk);
    #1;
    chk("stall busy", 64'(bus.i_rdy), 64'd0);
    @(posedge clk);
    #1;
    chk("stall vld", 64'(bus.o_vld), 64'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("stall hold vld", 64'(bus.o_vld), 64'd1);
      chk("stall hold flg", 64'(bus.o_flg), 64'(LT));
      chk("stall hold tos", 64'(bus.o_tos), 64'hFFFFFFFF);
      chk("stall no accept", 64'(bus.i_rdy), 64'd0);
    end
    @(negedge clk);
    bus.o_rdy = 1'b1;
    @(posedge clk);
    #1;
    bus.o_rdy = 1'b0;
    chk("stall exit vld", 64'(bus.o_vld), 64'd0);
    chk("stall exit idle", 64'(bus.i_rdy), 64'd1);
    @(posedge clk);
    #1;
    chk("stall reaccept", 64'(bus.i_rdy), 64'd0);
    bus.i_vld = 1'b0;
    @(posedge clk);
    #1;
    chk("stall second vld", 64'(bus.o_vld), 64'd1);
    chk("stall second flg", 64'(bus.o_flg), 64'(LT));
    @(negedge clk);
    bus.o_rdy = 1'b1;
    @(posedge clk);
    #1;
    bus.o_rdy = 1'b0;

    // Asynchronous reset in the third scan cycle of an EQ request
    @(negedge clk);
    bus.i_vld = 1'b1;
    bus.op    = OP_EQ;
    bus.a     = 32'h12345678;
    bus.b     = 32'h12345678;
    @(posedge clk);
    #1;
    bus.i_vld = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst i_rdy", 64'(bus.i_rdy), 64'd1);
    chk("arst o_vld", 64'(bus.o_vld), 64'd0);
    chk("arst o_flg", 64'(bus.o_flg), 64'd0);
    chk("arst o_tos", 64'(bus.o_tos), 64'd0);
    chk("arst o_err", 64'(bus.o_err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 12; k++) begin
        @(posedge clk);
        #1;
        if (bus.o_vld) seen++;
      end
      chk("arst no o_vld", 64'(seen), 64'd0);
    end
    req("post_rst", OP_EQ, 32'h12345678, 32'h12345678, EQ, 32'hFFFFFFFF, 1'b0, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
